// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-port word memory answering one request at a time after a fixed wait
module mem_responder #(
  parameter int byte_addr_p   = 10,
  parameter int wait_states_p = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [byte_addr_p-1:0] addr_i,
  input  logic                   rd_en_i,
  input  logic                   wr_en_i,
  input  logic [31:0]            mem_data_i,
  output logic [31:0]            mem_data_o,
  output logic                   ready_o,
  output logic                   err_o
);

  localparam int         words_lp     = 1 << (byte_addr_p - 2);
  localparam logic [3:0] wait_init_lp = 4'(wait_states_p);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_next;
  logic [3:0] count, count_next;
  logic       accept, access;

  logic [byte_addr_p-1:0] addr_q;
  logic [31:0]            data_q;
  logic                   rd_q, wr_q;

  logic [byte_addr_p-1:0] acc_addr;
  logic [byte_addr_p-3:0] acc_word;
  logic [31:0]            acc_data;
  logic                   acc_rd, acc_wr, acc_err;

  logic [31:0] mem [words_lp];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    accept     = 1'b0;
    access     = 1'b0;
    case (state)
      IDLE: begin
        if (rd_en_i || wr_en_i) begin
          accept = 1'b1;
          if (wait_states_p == 0) begin
            state_next = RESP;
            access     = 1'b1;
          end else begin
            state_next = WAIT;
            count_next = wait_init_lp;
          end
        end
      end
      WAIT: begin
        count_next = count - 4'd1;
        if (count == 4'd1) begin
          state_next = RESP;
          access     = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With zero wait states the access completes on the acceptance edge, so use the live inputs.
  always_comb begin
    if (state == IDLE) begin
      acc_addr = addr_i;
      acc_data = mem_data_i;
      acc_rd   = rd_en_i;
      acc_wr   = wr_en_i;
    end else begin
      acc_addr = addr_q;
      acc_data = data_q;
      acc_rd   = rd_q;
      acc_wr   = wr_q;
    end
    acc_word = acc_addr[byte_addr_p-1:2];
    acc_err  = (acc_addr[1:0] != 2'b00) || (acc_rd && acc_wr);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_o    <= 1'b0;
      err_o      <= 1'b0;
      mem_data_o <= 32'd0;
      addr_q     <= '0;
      data_q     <= 32'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      ready_o <= access;
      err_o   <= access && acc_err;
      if (accept) begin
        addr_q <= addr_i;
        data_q <= mem_data_i;
        rd_q   <= rd_en_i;
        wr_q   <= wr_en_i;
      end
      if (access && acc_err) begin
        mem_data_o <= 32'd0;
      end else if (access && acc_rd) begin
        mem_data_o <= mem[acc_word];
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && access && acc_wr && !acc_err) begin
      mem[acc_word] <= acc_data;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder at two wait-state settings
module tb_mem_responder;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          chk_data;
    bit          err;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        rd_en [2];
  logic        wr_en [2];
  logic [9:0]  addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  exp_t        sbq [2][$];
  logic [31:0] model [2][256];
  bit          known [2][256];
  logic [31:0] last_out [2];
  bit          last_known [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.byte_addr_p(10), .wait_states_p(2)) dut_w2 (
    .clk_i(clk), .rst_i(rst[0]), .addr_i(addr[0]), .rd_en_i(rd_en[0]), .wr_en_i(wr_en[0]),
    .mem_data_i(wdata[0]), .mem_data_o(rdata[0]), .ready_o(ready[0]), .err_o(err[0])
  );

  mem_responder #(.byte_addr_p(10), .wait_states_p(0)) dut_w0 (
    .clk_i(clk), .rst_i(rst[1]), .addr_i(addr[1]), .rd_en_i(rd_en[1]), .wr_en_i(wr_en[1]),
    .mem_data_i(wdata[1]), .mem_data_o(rdata[1]), .ready_o(ready[1]), .err_o(err[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Reference behaviour: each accepted request yields exactly one pulse wait+1 cycles later.
  task automatic req(input int k, input bit rd, input bit wr, input logic [9:0] a,
                     input logic [31:0] d, input bit intrude, input string nm);
    exp_t e;
    int   w;
    int   word;
    w = (k == 0) ? 2 : 0;
    word = int'(a[9:2]);
    @(negedge clk);
    rst[k] = 1'b0; rd_en[k] = rd; wr_en[k] = wr; addr[k] = a; wdata[k] = d;
    e.cyc = cyc + 1 + w;
    e.name = nm;
    e.err = (a[1:0] != 2'b00) || (rd && wr);
    if (e.err) begin
      e.data = 32'd0; e.chk_data = 1'b1;
      last_out[k] = 32'd0; last_known[k] = 1'b1;
    end else if (wr) begin
      model[k][word] = d; known[k][word] = 1'b1;
      e.data = last_out[k]; e.chk_data = last_known[k];
    end else begin
      e.data = model[k][word]; e.chk_data = known[k][word];
      last_out[k] = model[k][word]; last_known[k] = known[k][word];
    end
    sbq[k].push_back(e);
    @(negedge clk);
    rd_en[k] = 1'b0; wr_en[k] = 1'b0;
    if (intrude) begin
      wr_en[k] = 1'b1; addr[k] = a; wdata[k] = 32'h0AAA_AAAA;
    end
    @(negedge clk);
    wr_en[k] = 1'b0;
    repeat (w) @(negedge clk);
  endtask

  task automatic rst_mid(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en[0] = 1'b1; addr[0] = a; wdata[0] = d;
    @(negedge clk);
    wr_en[0] = 1'b0; rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("rst_mid_ready", {31'd0, ready[0]}, 32'd0);
    chk("rst_mid_err", {31'd0, err[0]}, 32'd0);
    chk("rst_mid_data", rdata[0], 32'd0);
    last_out[0] = 32'd0; last_known[0] = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic rand_ops(input int k, input int n);
    logic [9:0]  a;
    logic [31:0] d;
    bit          rd, wr;
    int          sel;
    for (int i = 0; i < n; i++) begin
      if (k == 0) a = {5'd0, 3'($urandom_range(0, 7)), 2'b00};
      else if ($urandom_range(0, 1) == 1) a = {8'(255 - $urandom_range(0, 3)), 2'b00};
      else a = {8'($urandom_range(0, 3)), 2'b00};
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      sel = $urandom_range(0, 9);
      rd = (sel < 5) || (sel == 9);
      wr = (sel >= 5);
      d = $urandom;
      req(k, rd, wr, a, d, ($urandom_range(0, 4) == 0), "random");
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (ready[k]) begin
        n_checks++;
        if (sbq[k].size() == 0) begin
          $display("FAIL unexpected_ready dut%0d: pulse at cycle %0d, expected none", k, cyc);
        end else begin
          e = sbq[k].pop_front();
          if (cyc == e.cyc && err[k] == e.err && (!e.chk_data || rdata[k] === e.data))
            n_pass++;
          else
            $display("FAIL %s dut%0d: cycle %0d data %h err %b, expected cycle %0d data %h err %b",
                     e.name, k, cyc, rdata[k], err[k], e.cyc, e.data, e.err);
        end
      end else if (err[k]) begin
        n_checks++;
        $display("FAIL err_without_ready dut%0d: err=1 ready=0 at cycle %0d, expected err only with ready", k, cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; rd_en[k] = 1'b1; wr_en[k] = 1'b1; addr[k] = 10'h010; wdata[k] = 32'h0BAD_0BAD;
      last_out[k] = 32'd0; last_known[k] = 1'b1;
      for (int j = 0; j < 256; j++) begin
        known[k][j] = 1'b0; model[k][j] = 32'd0;
      end
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      rd_en[k] = 1'b0; wr_en[k] = 1'b0;
      chk($sformatf("reset_ready%0d", k), {31'd0, ready[k]}, 32'd0);
      chk($sformatf("reset_err%0d", k), {31'd0, err[k]}, 32'd0);
      chk($sformatf("reset_data%0d", k), rdata[k], 32'd0);
    end

    req(0, 0, 1, 10'h010, 32'hDEAD_BEEF, 0, "wr_010");
    req(0, 1, 0, 10'h010, 32'h0, 0, "rd_010");
    req(0, 0, 1, 10'h012, 32'h1234_5678, 0, "wr_misaligned");
    req(0, 1, 0, 10'h010, 32'h0, 0, "rd_after_misaligned");
    req(0, 0, 1, 10'h020, 32'hCAFE_0020, 0, "wr_020");
    req(0, 1, 1, 10'h020, 32'hFFFF_FFFF, 0, "both_enables");
    req(0, 1, 0, 10'h020, 32'h0, 0, "rd_020_unchanged");
    req(0, 1, 0, 10'h010, 32'h0, 1, "rd_busy_drop");
    req(0, 1, 0, 10'h010, 32'h0, 0, "rd_after_drop");
    req(0, 0, 1, 10'h030, 32'h1111_1111, 0, "wr_030");
    rst_mid(10'h030, 32'h5555_5555);
    req(0, 1, 0, 10'h030, 32'h0, 0, "rd_030_after_reset");
    rand_ops(0, 40);

    req(1, 0, 1, 10'h3FC, 32'h0000_0001, 0, "w0_wr_3fc");
    req(1, 1, 0, 10'h3FC, 32'h0, 0, "w0_rd_3fc");
    req(1, 0, 1, 10'h000, 32'hA5A5_0000, 0, "w0_wr_000");
    req(1, 1, 0, 10'h3FC, 32'h0, 0, "w0_rd_3fc_again");
    req(1, 1, 0, 10'h000, 32'h0, 0, "w0_rd_000");
    req(1, 1, 0, 10'h3FE, 32'h0, 0, "w0_rd_misaligned");
    rand_ops(1, 40);

    repeat (10) @(negedge clk);
    chk("drain_dut0", 32'(sbq[0].size()), 32'd0);
    chk("drain_dut1", 32'(sbq[1].size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
